// File: rtl/db_sched_pkg.sv
// Shared types and width defaults for the double-buffer access scheduler.
package db_sched_pkg;

    localparam int DB_DEPTH_W = 16;
    localparam int DB_ITER_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SWAP,
        RUN,
        DRAIN
    } db_state_e;

endpackage

// File: rtl/db_bank_counter.sv
// Per-bank access counter: enabled up-count, synchronous clear, equals-limit flag.
module db_bank_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en) begin
            if (clr)
                count <= '0;
            else if (inc)
                count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/db_access_sched.sv
// Ping-pong sequencer in front of a double-buffered memory core: bounds per-bank
// writes/reads to the configured depth and swaps banks only when both sides finish.
module db_access_sched
    import db_sched_pkg::*;
#(
    parameter int DEPTH_W = DB_DEPTH_W,
    parameter int ITER_W  = DB_ITER_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               cfg_start,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic [ITER_W-1:0]  cfg_iters,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               out_req,
    output logic               out_grant,
    output logic               mem_wen,
    output logic               mem_ren,
    output logic               mem_switch_db,
    output logic [DEPTH_W-1:0] wr_count,
    output logic [DEPTH_W-1:0] rd_count,
    output logic               bank_sel,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    db_state_e          state, nxt;
    logic [DEPTH_W-1:0] depth_q;
    logic [ITER_W-1:0]  iters_q, fill_cnt;
    logic               switch_q;
    logic               wr_full, rd_full, wr_last, rd_last, cfg_ok, cnt_clr;

    assign cfg_ok  = (cfg_depth != '0) && (cfg_iters != '0);
    assign cnt_clr = (state == SWAP) || (state == IDLE && cfg_start && cfg_ok);

    db_bank_counter #(.W(DEPTH_W)) u_wr_cnt (
        .clk(clk), .reset(reset), .en(clk_en), .clr(cnt_clr), .inc(mem_wen),
        .limit(depth_q), .count(wr_count), .at_limit(wr_full)
    );

    db_bank_counter #(.W(DEPTH_W)) u_rd_cnt (
        .clk(clk), .reset(reset), .en(clk_en), .clr(cnt_clr), .inc(mem_ren),
        .limit(depth_q), .count(rd_count), .at_limit(rd_full)
    );

    // The access that fills a bank this cycle; outputs are already gated by clk_en.
    assign wr_last = mem_wen && (wr_count == depth_q - 1'b1);
    assign rd_last = mem_ren && (rd_count == depth_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (clk_en)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (cfg_start && cfg_ok) nxt = FILL;
            FILL:    if (wr_last) nxt = SWAP;
            SWAP:    nxt = (fill_cnt == iters_q) ? DRAIN : RUN;
            RUN:     if ((wr_full || wr_last) && (rd_full || rd_last)) nxt = SWAP;
            DRAIN:   if (rd_last) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_grant = 1'b0;
        if (clk_en) begin
            case (state)
                FILL:  in_ready = !wr_full;
                RUN: begin
                    in_ready  = !wr_full;
                    out_grant = out_req && !rd_full;
                end
                DRAIN: out_grant = out_req && !rd_full;
                default: ;
            endcase
        end
    end

    assign mem_wen       = in_valid && in_ready;
    assign mem_ren       = out_grant;
    assign mem_switch_db = switch_q && clk_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q  <= '0;
            iters_q  <= '0;
            fill_cnt <= '0;
            cfg_err  <= 1'b0;
            bank_sel <= 1'b0;
            switch_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clk_en) begin
            switch_q <= (nxt == SWAP);
            busy     <= (nxt != IDLE);
            done     <= (state == DRAIN) && (nxt == IDLE);
            if (state == IDLE && cfg_start) begin
                if (cfg_ok) begin
                    depth_q  <= cfg_depth;
                    iters_q  <= cfg_iters;
                    fill_cnt <= '0;
                    cfg_err  <= 1'b0;
                end else
                    cfg_err <= 1'b1;
            end
            if (wr_last)
                fill_cnt <= fill_cnt + 1'b1;
            if (state == SWAP)
                bank_sel <= ~bank_sel;
        end
    end

endmodule

// File: tb/tb_db_access_sched.sv
// Randomized and directed bench for db_access_sched against a transaction-count model.
module tb_db_access_sched;

    localparam int DW = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset, clk_en, cfg_start, in_valid, out_req;
    logic [DW-1:0] cfg_depth;
    logic [IW-1:0] cfg_iters;
    logic          in_ready, out_grant, mem_wen, mem_ren, mem_switch_db;
    logic [DW-1:0] wr_count, rd_count;
    logic          bank_sel, busy, done, cfg_err;

    db_access_sched #(.DEPTH_W(DW), .ITER_W(IW)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cfg_start(cfg_start),
        .cfg_depth(cfg_depth), .cfg_iters(cfg_iters), .in_valid(in_valid),
        .in_ready(in_ready), .out_req(out_req), .out_grant(out_grant),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_switch_db(mem_switch_db),
        .wr_count(wr_count), .rd_count(rd_count), .bank_sel(bank_sel),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: total words written/read in the run and swaps completed; bank counts derive from them.
    int m_w = 0, m_r = 0, m_s = 0, m_d = 0, m_n = 0;
    bit m_active = 0, m_swap = 0, m_done = 0, m_err = 0, m_bank = 0;

    function automatic int mwc();
        return m_w - m_s * m_d;
    endfunction

    function automatic int mrc();
        return (m_s == 0) ? 0 : m_r - (m_s - 1) * m_d;
    endfunction

    function automatic bit exp_ready();
        return clk_en && m_active && !m_swap && (m_w < m_n * m_d) && (mwc() < m_d);
    endfunction

    function automatic bit exp_grant();
        return clk_en && m_active && !m_swap && (m_s >= 1) && out_req && (mrc() < m_d);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit wen, gnt;
        wen = in_valid && exp_ready();
        gnt = exp_grant();
        if (reset) begin
            m_w = 0; m_r = 0; m_s = 0; m_d = 0; m_n = 0;
            m_active = 0; m_swap = 0; m_done = 0; m_err = 0; m_bank = 0;
        end else if (clk_en) begin
            m_done = 0;
            if (!m_active) begin
                if (cfg_start) begin
                    if (cfg_depth != 0 && cfg_iters != 0) begin
                        m_d = int'(cfg_depth); m_n = int'(cfg_iters);
                        m_w = 0; m_r = 0; m_s = 0; m_err = 0; m_active = 1;
                    end else
                        m_err = 1;
                end
            end else if (m_swap) begin
                m_s++; m_bank = ~m_bank; m_swap = 0;
            end else begin
                m_w += int'(wen);
                m_r += int'(gnt);
                if (m_s == m_n && mrc() == m_d) begin
                    m_active = 0; m_done = 1;
                end else if (mwc() == m_d && (m_s == 0 || mrc() == m_d))
                    m_swap = 1;
            end
        end
    end

    bit cmp_on = 0;
    int cyc = 0, nwen = 0, nren = 0, nsw = 0, ndone = 0, start_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            cyc++;
            chk("in_ready", in_ready, exp_ready());
            chk("out_grant", out_grant, exp_grant());
            chk("mem_wen", mem_wen, in_valid && exp_ready());
            chk("mem_ren", mem_ren, exp_grant());
            chk("mem_switch_db", mem_switch_db, m_swap && clk_en);
            chk("wr_count", wr_count, mwc());
            chk("rd_count", rd_count, mrc());
            chk("bank_sel", bank_sel, m_bank);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("cfg_err", cfg_err, m_err);
            if (mem_wen) nwen++;
            if (mem_ren) nren++;
            if (mem_switch_db) nsw++;
            if (done) begin ndone++; done_cyc = cyc; end
            if (cfg_start && clk_en && !m_active) start_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_cfg(input int d, input int n);
        clk_en = 1'b1;
        cfg_depth = DW'(d);
        cfg_iters = IW'(n);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit got;
        d0 = ndone;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (ndone != d0) got = 1;
        end
        chk("done_within_budget", got, 1'b1);
    endtask

    initial begin
        int w0, r0, s0;
        reset = 1'b1; clk_en = 1'b1; cfg_start = 1'b0; cfg_depth = '0; cfg_iters = '0;
        in_valid = 1'b0; out_req = 1'b0;
        tick(); tick();
        cmp_on = 1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_bank_sel", bank_sel, 1'b0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_switch", mem_switch_db, 1'b0);

        // depth 4, one fill, continuous traffic
        in_valid = 1'b1; out_req = 1'b1;
        w0 = nwen; r0 = nren; s0 = nsw;
        start_cfg(4, 1);
        wait_done(100);
        chk("t1_writes", nwen - w0, 4);
        chk("t1_reads", nren - r0, 4);
        chk("t1_swaps", nsw - s0, 1);
        chk("t1_latency", done_cyc - start_cyc, 10);
        chk("t1_bank_sel", bank_sel, 1'b1);

        // depth 3, three fills, continuous traffic
        do_reset();
        w0 = nwen; r0 = nren; s0 = nsw;
        start_cfg(3, 3);
        wait_done(100);
        chk("t2_writes", nwen - w0, 9);
        chk("t2_reads", nren - r0, 9);
        chk("t2_swaps", nsw - s0, 3);
        chk("t2_latency", done_cyc - start_cyc, 16);
        chk("t2_bank_sel", bank_sel, 1'b1);

        // reads withheld in RUN: write side stalls full
        out_req = 1'b0;
        r0 = nren; s0 = nsw;
        start_cfg(4, 2);
        repeat (12) tick();
        @(negedge clk);
        chk("t3_wr_full", wr_count, 4);
        chk("t3_in_ready_held", in_ready, 1'b0);
        chk("t3_wen_held", mem_wen, 1'b0);
        out_req = 1'b1;
        wait_done(100);
        chk("t3_reads", nren - r0, 8);
        chk("t3_swaps", nsw - s0, 2);

        // bad configuration then a good one
        tick();
        cfg_depth = '0; cfg_iters = IW'(2); cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        @(negedge clk);
        chk("t4_cfg_err", cfg_err, 1'b1);
        chk("t4_busy_idle", busy, 1'b0);
        tick();
        start_cfg(3, 1);
        @(negedge clk);
        chk("t4_busy", busy, 1'b1);
        chk("t4_cfg_err_clr", cfg_err, 1'b0);
        wait_done(100);

        // clock-enable pause mid-RUN
        do_reset();
        w0 = nwen; r0 = nren;
        start_cfg(5, 2);
        repeat (8) tick();
        clk_en = 1'b0;
        s0 = nsw;
        begin
            int pw, pr;
            pw = nwen; pr = nren;
            repeat (5) tick();
            chk("t5_no_wen", nwen - pw, 0);
            chk("t5_no_ren", nren - pr, 0);
            chk("t5_no_switch", nsw - s0, 0);
        end
        chk("t5_wr_hold", wr_count, 2);
        chk("t5_rd_hold", rd_count, 2);
        chk("t5_bank_hold", bank_sel, 1'b1);
        clk_en = 1'b1;
        wait_done(100);
        chk("t5_writes", nwen - w0, 10);
        chk("t5_reads", nren - r0, 10);

        // reset abort in RUN
        do_reset();
        start_cfg(5, 2);
        repeat (8) tick();
        chk("t6_wr_before", wr_count, 2);
        do_reset();
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_wr_count", wr_count, 0);
        chk("t6_in_ready", in_ready, 1'b0);
        chk("t6_bank_sel", bank_sel, 1'b0);

        // cfg_start while busy is ignored
        tick();
        w0 = nwen; s0 = nsw;
        start_cfg(2, 3);
        tick(); tick();
        cfg_depth = DW'(7); cfg_iters = IW'(1); cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_done(100);
        chk("t6_writes", nwen - w0, 6);
        chk("t6_swaps", nsw - s0, 3);

        // randomized traffic, enable gaps and ignored restarts
        for (int t = 0; t < 12; t++) begin
            int d0;
            bit got;
            tick();
            start_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
            d0 = ndone;
            got = 0;
            for (int i = 0; i < 600 && !got; i++) begin
                in_valid  = ($urandom % 4) != 0;
                out_req   = ($urandom % 3) != 0;
                clk_en    = ($urandom % 8) != 0;
                cfg_start = m_active && (($urandom % 16) == 0);
                cfg_depth = DW'($urandom_range(0, 6));
                cfg_iters = IW'($urandom_range(0, 3));
                tick();
                if (ndone != d0) got = 1;
            end
            cfg_start = 1'b0;
            clk_en = 1'b1;
            chk("rand_done", got, 1'b1);
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
